// File: rtl/fpu_norm_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu_norm_seq
// Brief    : Iterative post-add/sub mantissa normalizer with valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_norm_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 28,
    parameter int CNT_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic [CNT_W-1:0]  o_shift_cnt,
    output logic              o_zero,
    output logic              o_overflow,
    output logic              o_underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state, state_nxt;
    logic [EXP_W-1:0]    exp_q, exp_nxt, exp_inc;
    logic [MANT_W-1:0]   mant_q, mant_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic                zero_q, zero_nxt;
    logic                ovf_q, ovf_nxt;
    logic                unf_q, unf_nxt;

    assign exp_inc = exp_q + EXP_ONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            exp_q  <= '0;
            mant_q <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            exp_q  <= exp_nxt;
            mant_q <= mant_nxt;
            cnt_q  <= cnt_nxt;
            zero_q <= zero_nxt;
            ovf_q  <= ovf_nxt;
            unf_q  <= unf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        mant_nxt  = mant_q;
        cnt_nxt   = cnt_q;
        zero_nxt  = zero_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    exp_nxt  = i_exp;
                    mant_nxt = i_mant;
                    cnt_nxt  = '0;
                    zero_nxt = 1'b0;
                    unf_nxt  = 1'b0;
                    // Inf/NaN operands bypass normalization untouched
                    if (i_exp == EXP_MAX) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        ovf_nxt   = 1'b0;
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    exp_nxt   = '0;
                    zero_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    // Carry-out: shift right once, folding the lost bit into sticky
                    mant_nxt  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_nxt   = exp_inc;
                    if (exp_inc == EXP_MAX) begin
                        ovf_nxt  = 1'b1;
                        mant_nxt = '0;
                    end
                    state_nxt = DONE;
                end else if (mant_q[MANT_W-2]) begin
                    if (exp_q == '0) begin
                        exp_nxt = EXP_ONE;
                    end
                    state_nxt = DONE;
                end else if (exp_q <= EXP_ONE) begin
                    exp_nxt   = '0;
                    unf_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    mant_nxt = {mant_q[MANT_W-2:0], 1'b0};
                    exp_nxt  = exp_q - EXP_ONE;
                    cnt_nxt  = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_ready     = (state == IDLE);
    assign o_valid     = (state == DONE);
    assign o_exp       = exp_q;
    assign o_mant      = mant_q;
    assign o_shift_cnt = cnt_q;
    assign o_zero      = zero_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
`default_nettype wire
